// File: rtl/router_pkg.sv
// Shared definitions for the 1xN router controller: state encoding,
// state count and timer sizing helper.
package router_pkg;

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    FIFO_FULL_STATE    = 4'd3,
    LOAD_AFTER_FULL    = 4'd4,
    LOAD_PARITY        = 4'd5,
    CHECK_PARITY_ERROR = 4'd6,
    WAIT_TILL_EMPTY    = 4'd7,
    DROP_PACKET        = 4'd8
  } state_e;

  localparam int unsigned NUM_STATES = 9;
  localparam int unsigned STATE_W    = 4;

  // Bits needed to hold the wait-timer load value (tmo-1); never narrower than 1.
  function automatic int unsigned tmr_width(input int unsigned tmo);
    if (tmo < 2) return 1;
    return $clog2(tmo);
  endfunction

endpackage

// File: rtl/router_wait_timer.sv
// Down-counter bounding the time a packet may sit in WAIT_TILL_EMPTY.
// clr loads WAIT_TMO-1 on the edge that enters WAIT; the count then steps
// down once per WAIT cycle and expired is raised in the WAIT_TMO-th cycle.
// WAIT_TMO = 0 disables expiry entirely.
module router_wait_timer
  import router_pkg::*;
#(
  parameter int unsigned WAIT_TMO = 64
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned   TW       = tmr_width(WAIT_TMO);
  localparam int unsigned   LOAD_INT = (WAIT_TMO == 0) ? 0 : WAIT_TMO - 1;
  localparam logic [TW-1:0] LOAD_VAL = LOAD_INT[TW-1:0];
  localparam logic          TMO_ON   = (WAIT_TMO != 0);

  logic [TW-1:0] cnt_q, cnt_d;

  // Load on entry, then count down while waiting; park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expired = TMO_ON && en && (cnt_q == '0);

endmodule

// File: rtl/router_fsm_n.sv
// Control FSM for the 1xN packet router: header decode, load sequencing,
// source stall, invalid-address / timeout drop and drop counting.
//
//  state              | meaning
//  -------------------+--------------------------------------------------
//  DECODE_ADDRESS     | idle, waiting for a header; latches dest_sel
//  LOAD_FIRST_DATA    | header byte written to the selected FIFO
//  LOAD_DATA          | payload streaming
//  FIFO_FULL_STATE    | selected FIFO full, source stalled
//  LOAD_AFTER_FULL    | resume after full; decide parity / more payload
//  LOAD_PARITY        | parity byte written
//  CHECK_PARITY_ERROR | clear internal parity/error registers
//  WAIT_TILL_EMPTY    | target FIFO busy with an earlier packet
//  DROP_PACKET        | invalid address or wait timeout; bytes discarded
module router_fsm_n
  import router_pkg::*;
#(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned WAIT_TMO = 64,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic [NUM_CH-1:0] soft_reset,
  input  logic              low_pkt_valid,
  input  logic              parity_done,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_en_reg,
  output logic              rst_int_reg,
  output logic              busy,
  output logic              drop_state,
  output logic [ADDR_W-1:0] dest_sel,
  output logic              pkt_dropped,
  output logic [CNT_W-1:0]  drop_cnt
);

  // Address space may exceed the channel count; unused slots read as 0 so an
  // out-of-range dest_sel never sees "empty" or a soft reset.
  localparam int unsigned   NSEL     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] NUM_CH_V = NUM_CH[ADDR_W:0];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] dest_sel_q, dest_sel_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              pkt_dropped_q, pkt_dropped_d;

  logic [NSEL-1:0]   empty_ext;
  logic [NSEL-1:0]   srst_ext;
  logic              addr_ok;
  logic              tmr_clr;
  logic              tmr_en;
  logic              tmr_expired;
  logic              drop_entry;

  assign empty_ext = NSEL'(fifo_empty);
  assign srst_ext  = NSEL'(soft_reset);
  assign addr_ok   = ({1'b0, data_in} < NUM_CH_V);

  router_wait_timer #(
    .WAIT_TMO (WAIT_TMO)
  ) u_wait_timer (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  // Next-state and destination latch; soft reset of the selected channel overrides all.
  always_comb begin
    state_d    = state_q;
    dest_sel_d = dest_sel_q;
    case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid) begin
          dest_sel_d = data_in;
          if (!addr_ok)                 state_d = DROP_PACKET;
          else if (empty_ext[data_in])  state_d = LOAD_FIRST_DATA;
          else                          state_d = WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (empty_ext[dest_sel_q]) state_d = LOAD_FIRST_DATA;
        else if (tmr_expired)      state_d = DROP_PACKET;
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        // fifo_full takes precedence over end of packet
        if (fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end
      LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        if (fifo_full) state_d = FIFO_FULL_STATE;
        else           state_d = DECODE_ADDRESS;
      end
      DROP_PACKET: begin
        if (!pkt_valid) state_d = DECODE_ADDRESS;
      end
      default: state_d = DECODE_ADDRESS;
    endcase

    if ((state_q != DECODE_ADDRESS) && srst_ext[dest_sel_q]) begin
      state_d = DECODE_ADDRESS;
    end
  end

  // Timer control, drop pulse and saturating drop counter.
  always_comb begin
    tmr_en        = (state_q == WAIT_TILL_EMPTY);
    tmr_clr       = (state_d == WAIT_TILL_EMPTY) && (state_q != WAIT_TILL_EMPTY);
    drop_entry    = (state_d == DROP_PACKET) && (state_q != DROP_PACKET);
    pkt_dropped_d = drop_entry;
    drop_cnt_d    = drop_cnt_q;
    if (drop_entry && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= DECODE_ADDRESS;
      dest_sel_q    <= '0;
      drop_cnt_q    <= '0;
      pkt_dropped_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dest_sel_q    <= dest_sel_d;
      drop_cnt_q    <= drop_cnt_d;
      pkt_dropped_q <= pkt_dropped_d;
    end
  end

  assign detect_add   = (state_q == DECODE_ADDRESS);
  assign lfd_state    = (state_q == LOAD_FIRST_DATA);
  assign ld_state     = (state_q == LOAD_DATA);
  assign laf_state    = (state_q == LOAD_AFTER_FULL);
  assign full_state   = (state_q == FIFO_FULL_STATE);
  assign write_en_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                        (state_q == LOAD_AFTER_FULL);
  assign rst_int_reg  = (state_q == CHECK_PARITY_ERROR);
  assign busy         = (state_q == LOAD_FIRST_DATA) || (state_q == FIFO_FULL_STATE) ||
                        (state_q == LOAD_AFTER_FULL) || (state_q == LOAD_PARITY) ||
                        (state_q == CHECK_PARITY_ERROR) || (state_q == WAIT_TILL_EMPTY);
  assign drop_state   = (state_q == DROP_PACKET);
  assign dest_sel     = dest_sel_q;
  assign pkt_dropped  = pkt_dropped_q;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_router_fsm_n.sv
// Bench for router_fsm_n. Main instance uses the default 64-cycle wait
// timeout; a second instance with WAIT_TMO=4, CNT_W=2 covers timeout and
// counter saturation. Expected outputs are derived from the state the bench
// expects, pushed at drive time and compared once the DUT has clocked.
module tb_router_fsm_n;
  import router_pkg::*;

  logic       clk;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] soft_reset;
  logic       low_pkt_valid;
  logic       parity_done;

  logic detect_add, lfd_state, ld_state, laf_state, full_state;
  logic write_en_reg, rst_int_reg, busy, drop_state, pkt_dropped;
  logic [1:0] dest_sel;
  logic [7:0] drop_cnt;

  logic detect_add_t, lfd_state_t, ld_state_t, laf_state_t, full_state_t;
  logic write_en_reg_t, rst_int_reg_t, busy_t, drop_state_t, pkt_dropped_t;
  logic [1:0] dest_sel_t;
  logic [1:0] drop_cnt_t;

  logic [9:0] obs, obs_t;
  assign obs   = {detect_add, lfd_state, ld_state, laf_state, full_state,
                  write_en_reg, rst_int_reg, busy, drop_state, pkt_dropped};
  assign obs_t = {detect_add_t, lfd_state_t, ld_state_t, laf_state_t, full_state_t,
                  write_en_reg_t, rst_int_reg_t, busy_t, drop_state_t, pkt_dropped_t};

  router_fsm_n #(.NUM_CH(3), .ADDR_W(2), .WAIT_TMO(64), .CNT_W(8)) dut (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .low_pkt_valid(low_pkt_valid), .parity_done(parity_done),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_en_reg(write_en_reg),
    .rst_int_reg(rst_int_reg), .busy(busy), .drop_state(drop_state),
    .dest_sel(dest_sel), .pkt_dropped(pkt_dropped), .drop_cnt(drop_cnt)
  );

  router_fsm_n #(.NUM_CH(3), .ADDR_W(2), .WAIT_TMO(4), .CNT_W(2)) dut_t (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .low_pkt_valid(low_pkt_valid), .parity_done(parity_done),
    .detect_add(detect_add_t), .lfd_state(lfd_state_t), .ld_state(ld_state_t),
    .laf_state(laf_state_t), .full_state(full_state_t), .write_en_reg(write_en_reg_t),
    .rst_int_reg(rst_int_reg_t), .busy(busy_t), .drop_state(drop_state_t),
    .dest_sel(dest_sel_t), .pkt_dropped(pkt_dropped_t), .drop_cnt(drop_cnt_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] o;
    logic [1:0] dsel;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    logic       pv;
    logic [1:0] d;
    logic       ff;
    logic [2:0] fe;
    logic [2:0] sr;
    logic       lpv;
    logic       pd;
    state_e     s;
    logic       pdp;
    logic [1:0] ds;
    logic [7:0] c;
  } row_t;

  exp_t sb[$];
  exp_t obq[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  // Output vector implied by a state, written from the output definitions.
  function automatic logic [9:0] dec(input state_e s, input logic pdp);
    logic [9:0] v;
    v    = '0;
    v[9] = (s == DECODE_ADDRESS);
    v[8] = (s == LOAD_FIRST_DATA);
    v[7] = (s == LOAD_DATA);
    v[6] = (s == LOAD_AFTER_FULL);
    v[5] = (s == FIFO_FULL_STATE);
    v[4] = (s == LOAD_DATA) || (s == LOAD_PARITY) || (s == LOAD_AFTER_FULL);
    v[3] = (s == CHECK_PARITY_ERROR);
    v[2] = !((s == DECODE_ADDRESS) || (s == LOAD_DATA) || (s == DROP_PACKET));
    v[1] = (s == DROP_PACKET);
    v[0] = pdp;
    return v;
  endfunction

  function automatic row_t r(input logic pv, input logic [1:0] d, input logic ff,
                             input logic [2:0] fe, input logic [2:0] sr, input logic lpv,
                             input logic pd, input state_e s, input logic pdp,
                             input logic [1:0] ds, input logic [7:0] c);
    row_t x;
    x.pv = pv; x.d = d; x.ff = ff; x.fe = fe; x.sr = sr; x.lpv = lpv; x.pd = pd;
    x.s = s; x.pdp = pdp; x.ds = ds; x.c = c;
    return x;
  endfunction

  // Drive one cycle of inputs, record expectation and the post-edge observation.
  task automatic apply(input row_t x, input bit use_t);
    exp_t e, o;
    @(negedge clk);
    pkt_valid = x.pv; data_in = x.d; fifo_full = x.ff; fifo_empty = x.fe;
    soft_reset = x.sr; low_pkt_valid = x.lpv; parity_done = x.pd;
    e.o = dec(x.s, x.pdp); e.dsel = x.ds; e.cnt = x.c;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (use_t) begin
      o.o = obs_t; o.dsel = dest_sel_t; o.cnt = {6'b0, drop_cnt_t};
    end else begin
      o.o = obs; o.dsel = dest_sel; o.cnt = drop_cnt;
    end
    obq.push_back(o);
  endtask

  task automatic idle_inputs();
    pkt_valid = 0; data_in = 0; fifo_full = 0; fifo_empty = 3'b111;
    soft_reset = 0; low_pkt_valid = 0; parity_done = 0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    idle_inputs();
    resetn = 0;
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 0;
    #3;
    n_cmp++;
    if ({obs, dest_sel, drop_cnt} !== {dec(DECODE_ADDRESS, 1'b0), 2'd0, 8'd0}) begin
      n_mis++;
      $display("FAIL reset got out=%b dsel=%0d cnt=%0d want out=%b dsel=0 cnt=0",
               obs, dest_sel, drop_cnt, dec(DECODE_ADDRESS, 1'b0));
    end
    n_cmp++;
    if ({obs_t, dest_sel_t, drop_cnt_t} !== {dec(DECODE_ADDRESS, 1'b0), 2'd0, 2'd0}) begin
      n_mis++;
      $display("FAIL reset_t got out=%b dsel=%0d cnt=%0d want out=%b dsel=0 cnt=0",
               obs_t, dest_sel_t, drop_cnt_t, dec(DECODE_ADDRESS, 1'b0));
    end
    @(negedge clk);
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic drain(input string name);
    exp_t e, o;
    int   i;
    i = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obq.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_mis++;
        $display("FAIL %s[%0d] got out=%b dsel=%0d cnt=%0d want out=%b dsel=%0d cnt=%0d",
                 name, i, o.o, o.dsel, o.cnt, e.o, e.dsel, e.cnt);
      end
      i++;
    end
  endtask

  task automatic test_normal();
    apply(r(1, 1, 0, 3'b111, 0, 0, 0, LOAD_FIRST_DATA,    0, 1, 0), 0);
    apply(r(1, 1, 0, 3'b111, 0, 0, 0, LOAD_DATA,          0, 1, 0), 0);
    apply(r(1, 1, 0, 3'b111, 0, 0, 0, LOAD_DATA,          0, 1, 0), 0);
    apply(r(0, 1, 0, 3'b111, 0, 0, 0, LOAD_PARITY,        0, 1, 0), 0);
    apply(r(0, 1, 0, 3'b111, 0, 0, 0, CHECK_PARITY_ERROR, 0, 1, 0), 0);
    apply(r(0, 1, 0, 3'b111, 0, 0, 0, DECODE_ADDRESS,     0, 1, 0), 0);
    apply(r(0, 1, 0, 3'b111, 0, 0, 0, DECODE_ADDRESS,     0, 1, 0), 0);
    drain("normal");
  endtask

  task automatic test_wait();
    for (int k = 0; k < 5; k++)
      apply(r(1, 2, 0, 3'b011, 0, 0, 0, WAIT_TILL_EMPTY, 0, 2, 0), 0);
    apply(r(1, 2, 0, 3'b111, 0, 0, 0, LOAD_FIRST_DATA,    0, 2, 0), 0);
    apply(r(1, 2, 0, 3'b111, 0, 0, 0, LOAD_DATA,          0, 2, 0), 0);
    apply(r(0, 2, 0, 3'b111, 0, 0, 0, LOAD_PARITY,        0, 2, 0), 0);
    apply(r(0, 2, 0, 3'b111, 0, 0, 0, CHECK_PARITY_ERROR, 0, 2, 0), 0);
    apply(r(0, 2, 0, 3'b111, 0, 0, 0, DECODE_ADDRESS,     0, 2, 0), 0);
    drain("wait");
  endtask

  task automatic test_full();
    apply(r(1, 0, 0, 3'b111, 0, 0, 0, LOAD_FIRST_DATA,    0, 0, 0), 0);
    apply(r(1, 0, 0, 3'b111, 0, 0, 0, LOAD_DATA,          0, 0, 0), 0);
    apply(r(0, 0, 1, 3'b111, 0, 0, 0, FIFO_FULL_STATE,    0, 0, 0), 0);
    apply(r(0, 0, 1, 3'b111, 0, 0, 0, FIFO_FULL_STATE,    0, 0, 0), 0);
    apply(r(0, 0, 0, 3'b111, 0, 0, 0, LOAD_AFTER_FULL,    0, 0, 0), 0);
    apply(r(0, 0, 0, 3'b111, 0, 1, 0, LOAD_PARITY,        0, 0, 0), 0);
    apply(r(0, 0, 0, 3'b111, 0, 0, 0, CHECK_PARITY_ERROR, 0, 0, 0), 0);
    apply(r(0, 0, 0, 3'b111, 0, 0, 0, DECODE_ADDRESS,     0, 0, 0), 0);
    drain("full");
  endtask

  task automatic test_back_to_back();
    apply(r(1, 1, 0, 3'b111, 0, 0, 0, LOAD_FIRST_DATA,    0, 1, 0), 0);
    apply(r(1, 1, 0, 3'b111, 0, 0, 0, LOAD_DATA,          0, 1, 0), 0);
    apply(r(1, 1, 1, 3'b111, 0, 0, 0, FIFO_FULL_STATE,    0, 1, 0), 0);
    apply(r(1, 1, 0, 3'b111, 0, 0, 0, LOAD_AFTER_FULL,    0, 1, 0), 0);
    apply(r(1, 1, 0, 3'b111, 0, 0, 0, LOAD_DATA,          0, 1, 0), 0);
    apply(r(1, 1, 1, 3'b111, 0, 0, 0, FIFO_FULL_STATE,    0, 1, 0), 0);
    apply(r(1, 1, 0, 3'b111, 0, 0, 0, LOAD_AFTER_FULL,    0, 1, 0), 0);
    apply(r(1, 2, 0, 3'b111, 0, 0, 1, DECODE_ADDRESS,     0, 1, 0), 0);
    apply(r(1, 2, 0, 3'b111, 0, 0, 0, LOAD_FIRST_DATA,    0, 2, 0), 0);
    apply(r(1, 2, 0, 3'b111, 0, 0, 0, LOAD_DATA,          0, 2, 0), 0);
    apply(r(0, 2, 0, 3'b111, 0, 0, 0, LOAD_PARITY,        0, 2, 0), 0);
    apply(r(0, 2, 0, 3'b111, 0, 0, 0, CHECK_PARITY_ERROR, 0, 2, 0), 0);
    apply(r(0, 2, 1, 3'b111, 0, 0, 0, FIFO_FULL_STATE,    0, 2, 0), 0);
    apply(r(0, 2, 0, 3'b111, 0, 0, 0, LOAD_AFTER_FULL,    0, 2, 0), 0);
    apply(r(0, 2, 0, 3'b111, 0, 0, 1, DECODE_ADDRESS,     0, 2, 0), 0);
    drain("b2b");
  endtask

  task automatic test_drop();
    apply(r(1, 3, 0, 3'b111, 0, 0, 0, DROP_PACKET,    1, 3, 1), 0);
    apply(r(1, 3, 0, 3'b111, 0, 0, 0, DROP_PACKET,    0, 3, 1), 0);
    apply(r(1, 0, 0, 3'b111, 0, 0, 0, DROP_PACKET,    0, 3, 1), 0);
    apply(r(0, 0, 0, 3'b111, 0, 0, 0, DECODE_ADDRESS, 0, 3, 1), 0);
    drain("drop");
  endtask

  task automatic test_reset_mid();
    apply(r(1, 0, 0, 3'b111, 0, 0, 0, LOAD_FIRST_DATA, 0, 0, 1), 0);
    apply(r(1, 0, 0, 3'b111, 0, 0, 0, LOAD_DATA,       0, 0, 1), 0);
    drain("pre_rst");
    #2;
    resetn = 0;
    #1;
    n_cmp++;
    if ({detect_add, busy, ld_state, drop_cnt} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
      n_mis++;
      $display("FAIL reset_mid got detect=%b busy=%b ld=%b cnt=%0d want detect=1 busy=0 ld=0 cnt=0",
               detect_add, busy, ld_state, drop_cnt);
    end
    @(negedge clk);
    idle_inputs();
    resetn = 1;
  endtask

  task automatic test_timeout();
    for (int k = 0; k < 4; k++)
      apply(r(1, 0, 0, 3'b110, 0, 0, 0, WAIT_TILL_EMPTY, 0, 0, 0), 1);
    apply(r(1, 0, 0, 3'b110, 0, 0, 0, DROP_PACKET,    1, 0, 1), 1);
    apply(r(1, 0, 0, 3'b110, 0, 0, 0, DROP_PACKET,    0, 0, 1), 1);
    apply(r(0, 0, 0, 3'b110, 0, 0, 0, DECODE_ADDRESS, 0, 0, 1), 1);
    drain("timeout");
    n_cmp++;
    if ({obs, drop_cnt} !== {dec(WAIT_TILL_EMPTY, 1'b0), 8'd0}) begin
      n_mis++;
      $display("FAIL long_wait got out=%b cnt=%0d want out=%b cnt=0",
               obs, drop_cnt, dec(WAIT_TILL_EMPTY, 1'b0));
    end
  endtask

  task automatic test_soft_reset();
    reset_pulse();
    apply(r(1, 0, 0, 3'b111, 3'b000, 0, 0, LOAD_FIRST_DATA, 0, 0, 0), 0);
    apply(r(1, 0, 0, 3'b111, 3'b000, 0, 0, LOAD_DATA,       0, 0, 0), 0);
    apply(r(1, 0, 1, 3'b111, 3'b000, 0, 0, FIFO_FULL_STATE, 0, 0, 0), 0);
    apply(r(1, 0, 1, 3'b111, 3'b110, 0, 0, FIFO_FULL_STATE, 0, 0, 0), 0);
    apply(r(1, 0, 1, 3'b111, 3'b001, 0, 0, DECODE_ADDRESS,  0, 0, 0), 0);
    apply(r(0, 0, 0, 3'b111, 3'b001, 0, 0, DECODE_ADDRESS,  0, 0, 0), 0);
    drain("soft_rst");
  endtask

  task automatic test_saturate();
    logic [7:0] c;
    reset_pulse();
    for (int k = 0; k < 4; k++) begin
      c = (k < 3) ? 8'(k + 1) : 8'd3;
      apply(r(1, 3, 0, 3'b111, 0, 0, 0, DROP_PACKET,    1, 3, c), 1);
      apply(r(0, 3, 0, 3'b111, 0, 0, 0, DECODE_ADDRESS, 0, 3, c), 1);
    end
    drain("saturate");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_normal();
    test_wait();
    test_full();
    test_back_to_back();
    test_drop();
    test_reset_mid();
    test_timeout();
    test_soft_reset();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
